// File: rtl/digit_serial_adder.sv
// digit_serial_adder
//   Multi-cycle adder/subtractor. A WIDTH-bit operand pair is processed one DIGIT-bit slice
//   per clock, LSB slice first, through a single slice adder with a registered carry.
//
// Parameters
//   WIDTH  operand/result width (integer multiple of DIGIT)
//   DIGIT  bits processed per clock
//
// Ports
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  begin an operation (accepted in idle or in the done cycle)
//   sub    0 = add, 1 = subtract (captured with start)
//   x, y   operands (captured with start)
//   c_in   carry-in for add, borrow-in for subtract (captured with start)
//   busy   operation in progress
//   done   one-cycle completion pulse
//   sum    registered result
//   c_out  carry-out (for subtract, 1 = no borrow)
//   ovf    two's-complement signed overflow
module digit_serial_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int unsigned NDigits = WIDTH / DIGIT;
  localparam int unsigned CntW    = (NDigits > 1) ? $clog2(NDigits) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NDigits - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic [CntW-1:0]  cnt_q;

  // Single DIGIT-bit slice adder.
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT:0]   slice;
  logic             msb_cin;
  logic             slice_ovf;
  logic [WIDTH-1:0] res_shift;

  always_comb begin
    a_dig     = a_q[DIGIT-1:0];
    b_dig     = b_q[DIGIT-1:0];
    slice     = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
    // Carry into the slice MSB recovered from the MSB sum bit; only meaningful on the last digit.
    msb_cin   = a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ slice[DIGIT-1];
    slice_ovf = msb_cin ^ slice[DIGIT];
  end

  // Result digits enter at the top so after NDigits shifts the LSB digit sits at bit 0.
  if (NDigits == 1) begin : g_single
    assign res_shift = slice[DIGIT-1:0];
  end else begin : g_multi
    assign res_shift = {slice[DIGIT-1:0], res_q[WIDTH-1:DIGIT]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      c_out   <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          done <= 1'b0;
          if (start) begin
            a_q     <= x;
            // Subtract as x + ~y + ~borrow, i.e. x - y - c_in.
            b_q     <= sub ? ~y : y;
            carry_q <= sub ? ~c_in : c_in;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          res_q   <= res_shift;
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          carry_q <= slice[DIGIT];
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            sum     <= res_shift;
            c_out   <= slice[DIGIT];
            ovf     <= slice_ovf;
            busy    <= 1'b0;
            done    <= 1'b1;
            cnt_q   <= '0;
            state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
module tb_digit_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (WIDTH=16, DIGIT=4)
  logic        rst, start, sub, c_in;
  logic [15:0] x, y;
  logic        busy, done, c_out, ovf;
  logic [15:0] sum;

  // Parameter sweep instances
  logic        sw_start, sw_sub, sw_cin;
  logic [15:0] sw_x16, sw_y16;
  logic [31:0] sw_x32, sw_y32;
  logic        a_busy, a_done, a_cout, a_ovf;
  logic [15:0] a_sum;
  logic        b_busy, b_done, b_cout, b_ovf;
  logic [15:0] b_sum;
  logic        c_busy, c_done, c_cout, c_ovf;
  logic [31:0] c_sum;

  int checks = 0;
  int errors = 0;

  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .x(x), .y(y), .c_in(c_in),
    .busy(busy), .done(done), .sum(sum), .c_out(c_out), .ovf(ovf)
  );

  digit_serial_adder #(.WIDTH(16), .DIGIT(16)) dut_d16 (
    .clk(clk), .rst(rst), .start(sw_start), .sub(sw_sub), .x(sw_x16), .y(sw_y16),
    .c_in(sw_cin), .busy(a_busy), .done(a_done), .sum(a_sum), .c_out(a_cout), .ovf(a_ovf)
  );

  digit_serial_adder #(.WIDTH(16), .DIGIT(1)) dut_d1 (
    .clk(clk), .rst(rst), .start(sw_start), .sub(sw_sub), .x(sw_x16), .y(sw_y16),
    .c_in(sw_cin), .busy(b_busy), .done(b_done), .sum(b_sum), .c_out(b_cout), .ovf(b_ovf)
  );

  digit_serial_adder #(.WIDTH(32), .DIGIT(8)) dut_w32 (
    .clk(clk), .rst(rst), .start(sw_start), .sub(sw_sub), .x(sw_x32), .y(sw_y32),
    .c_in(sw_cin), .busy(c_busy), .done(c_done), .sum(c_sum), .c_out(c_cout), .ovf(c_ovf)
  );

  // Reference: plain unsigned and signed integer arithmetic over w bits.
  function automatic void model(input int unsigned w, input logic [31:0] a, input logic [31:0] b,
                                input logic s, input logic ci, output logic [31:0] r,
                                output logic co, output logic ov);
    longint unsigned m, ua, ub, uc, u;
    longint          sa, sb, sr, half;
    m  = 64'd1 << w;
    ua = a;
    ub = b;
    uc = {63'd0, ci};
    sa = a[w-1] ? longint'(ua) - longint'(m) : longint'(ua);
    sb = b[w-1] ? longint'(ub) - longint'(m) : longint'(ub);
    if (!s) begin
      u  = ua + ub + uc;
      co = (u >= m);
      sr = sa + sb + longint'(uc);
    end else begin
      co = (ua >= ub + uc);
      u  = ua + m - ub - uc;
      sr = sa - sb - longint'(uc);
    end
    r    = 32'(u % m);
    half = longint'(m >> 1);
    ov   = (sr >= half) || (sr < -half);
  endfunction

  // Drive one start pulse; returns at the negedge just after the start edge.
  task automatic pulse_start(input logic s, input logic [15:0] a, input logic [15:0] b,
                             input logic ci);
    @(negedge clk);
    sub = s; x = a; y = b; c_in = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count negedges until done (bounded); lat = edges after the start edge.
  task automatic wait_done(output int lat, output int bcyc);
    lat = 0;
    bcyc = 0;
    while (!done && lat < 50) begin
      if (busy) bcyc++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (sum !== 16'h0) begin errors++; $display("FAIL reset_sum: got %h want 0000", sum); end
    checks++; if (c_out !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want 0", c_out); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    rst = 1'b0;
  endtask

  task automatic test_add();
    int lat, bcyc;
    pulse_start(1'b0, 16'h1234, 16'h4321, 1'b0);
    wait_done(lat, bcyc);
    checks++; if (lat != 4) begin errors++; $display("FAIL add_latency: got %0d want 4", lat); end
    checks++; if (bcyc != 4) begin errors++; $display("FAIL add_busy_cycles: got %0d want 4", bcyc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL add_busy_at_done: got %b want 0", busy); end
    checks++; if (sum !== 16'h5555) begin errors++; $display("FAIL add_sum: got %h want 5555", sum); end
    checks++; if (c_out !== 1'b0) begin errors++; $display("FAIL add_cout: got %b want 0", c_out); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL add_ovf: got %b want 0", ovf); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL add_done_pulse: got %b want 0", done); end
    checks++; if (sum !== 16'h5555) begin errors++; $display("FAIL add_sum_hold: got %h want 5555", sum); end
  endtask

  task automatic test_carry_ovf();
    logic [15:0] va [3] = '{16'hFFFF, 16'h7FFF, 16'h0000};
    logic [15:0] vb [3] = '{16'h0001, 16'h0001, 16'h0000};
    logic        vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [15:0] es [3] = '{16'h0000, 16'h8000, 16'h0001};
    logic        eco[3] = '{1'b1, 1'b0, 1'b0};
    logic        eov[3] = '{1'b0, 1'b1, 1'b0};
    int lat, bcyc;
    for (int i = 0; i < 3; i++) begin
      pulse_start(1'b0, va[i], vb[i], vc[i]);
      wait_done(lat, bcyc);
      checks++; if (sum !== es[i]) begin errors++; $display("FAIL carry_sum[%0d]: got %h want %h", i, sum, es[i]); end
      checks++; if (c_out !== eco[i]) begin errors++; $display("FAIL carry_cout[%0d]: got %b want %b", i, c_out, eco[i]); end
      checks++; if (ovf !== eov[i]) begin errors++; $display("FAIL carry_ovf[%0d]: got %b want %b", i, ovf, eov[i]); end
    end
  endtask

  task automatic test_subtract();
    logic [15:0] va [3] = '{16'h0005, 16'h8000, 16'h0010};
    logic [15:0] vb [3] = '{16'h0007, 16'h0001, 16'h0001};
    logic        vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [15:0] es [3] = '{16'hFFFE, 16'h7FFF, 16'h000E};
    logic        eco[3] = '{1'b0, 1'b1, 1'b1};
    logic        eov[3] = '{1'b0, 1'b1, 1'b0};
    int lat, bcyc;
    for (int i = 0; i < 3; i++) begin
      pulse_start(1'b1, va[i], vb[i], vc[i]);
      wait_done(lat, bcyc);
      checks++; if (sum !== es[i]) begin errors++; $display("FAIL sub_sum[%0d]: got %h want %h", i, sum, es[i]); end
      checks++; if (c_out !== eco[i]) begin errors++; $display("FAIL sub_cout[%0d]: got %b want %b", i, c_out, eco[i]); end
      checks++; if (ovf !== eov[i]) begin errors++; $display("FAIL sub_ovf[%0d]: got %b want %b", i, ovf, eov[i]); end
    end
  endtask

  // Random operations with inputs scrambled during RUN; outputs must hold the previous result.
  task automatic test_random_toggle();
    logic [31:0] er, prev;
    logic        eco, eov, s, ci;
    logic [15:0] a, b;
    int          lat;
    prev = 32'h0000_000E;  // result of the last subtract vector
    for (int k = 0; k < 20; k++) begin
      a = 16'($urandom); b = 16'($urandom); s = 1'($urandom); ci = 1'($urandom);
      model(16, {16'h0, a}, {16'h0, b}, s, ci, er, eco, eov);
      pulse_start(s, a, b, ci);
      lat = 0;
      while (!done && lat < 50) begin
        checks++;
        if (sum !== prev[15:0]) begin errors++; $display("FAIL rand_hold[%0d]: got %h want %h", k, sum, prev[15:0]); end
        x = 16'($urandom); y = 16'($urandom); sub = 1'($urandom); c_in = 1'($urandom);
        @(negedge clk);
        lat++;
      end
      checks++; if (lat != 4) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want 4", k, lat); end
      checks++;
      if ({sum, c_out, ovf} !== {er[15:0], eco, eov}) begin
        errors++;
        $display("FAIL rand_result[%0d]: got %h/%b/%b want %h/%b/%b", k, sum, c_out, ovf, er[15:0], eco, eov);
      end
      prev = er;
    end
  endtask

  task automatic test_start_ignored();
    int lat, bcyc;
    pulse_start(1'b0, 16'h1111, 16'h2222, 1'b0);
    @(negedge clk);
    sub = 1'b1; x = 16'hFFFF; y = 16'h0F0F; c_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bcyc);
    lat += 2;
    checks++; if (lat != 4) begin errors++; $display("FAIL ignore_latency: got %0d want 4", lat); end
    checks++; if (sum !== 16'h3333) begin errors++; $display("FAIL ignore_sum: got %h want 3333", sum); end
    checks++; if (c_out !== 1'b0) begin errors++; $display("FAIL ignore_cout: got %b want 0", c_out); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat, bcyc;
    pulse_start(1'b0, 16'h00FF, 16'h0F01, 1'b0);
    wait_done(lat, bcyc);
    checks++; if (sum !== 16'h1000) begin errors++; $display("FAIL b2b_first_sum: got %h want 1000", sum); end
    sub = 1'b1; x = 16'h0100; y = 16'h0001; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart_busy: got %b want 1", busy); end
    wait_done(lat, bcyc);
    checks++; if (lat != 4) begin errors++; $display("FAIL b2b_latency: got %0d want 4", lat); end
    checks++; if (sum !== 16'h00FF) begin errors++; $display("FAIL b2b_second_sum: got %h want 00ff", sum); end
    checks++; if (c_out !== 1'b1) begin errors++; $display("FAIL b2b_second_cout: got %b want 1", c_out); end
  endtask

  task automatic test_reset_mid();
    int lat, bcyc, seen;
    pulse_start(1'b0, 16'h1234, 16'h1111, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (sum !== 16'h0) begin errors++; $display("FAIL rstmid_sum: got %h want 0000", sum); end
    checks++; if (c_out !== 1'b0) begin errors++; $display("FAIL rstmid_cout: got %b want 0", c_out); end
    seen = 0;
    repeat (8) begin
      if (done) seen++;
      @(negedge clk);
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses want 0", seen); end
    // Reset wins over a simultaneous start.
    rst = 1'b1; start = 1'b1; sub = 1'b0; x = 16'h0001; y = 16'h0001;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_priority_busy: got %b want 0", busy); end
    pulse_start(1'b0, 16'hABCD, 16'h1111, 1'b1);
    wait_done(lat, bcyc);
    checks++; if (lat != 4) begin errors++; $display("FAIL rstmid_restart_latency: got %0d want 4", lat); end
    checks++; if (sum !== 16'hBCDF) begin errors++; $display("FAIL rstmid_restart_sum: got %h want bcdf", sum); end
  endtask

  task automatic test_param_sweep();
    logic [31:0] r16, r32;
    logic        co16, ov16, co32, ov32;
    int          la, lb, lc, n;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      sw_x16 = 16'($urandom); sw_y16 = 16'($urandom);
      sw_x32 = $urandom; sw_y32 = $urandom;
      sw_sub = 1'($urandom); sw_cin = 1'($urandom);
      if (k == 0) begin sw_x16 = 16'h7FFF; sw_y16 = 16'h0001; sw_sub = 1'b0; sw_cin = 1'b0; end
      if (k == 1) begin sw_x32 = 32'h8000_0000; sw_y32 = 32'h0000_0001; sw_sub = 1'b1; sw_cin = 1'b0; end
      model(16, {16'h0, sw_x16}, {16'h0, sw_y16}, sw_sub, sw_cin, r16, co16, ov16);
      model(32, sw_x32, sw_y32, sw_sub, sw_cin, r32, co32, ov32);
      sw_start = 1'b1;
      @(negedge clk);
      sw_start = 1'b0;
      la = -1; lb = -1; lc = -1; n = 0;
      while (n < 40) begin
        if (la < 0 && a_done) begin
          la = n;
          checks++;
          if ({a_sum, a_cout, a_ovf} !== {r16[15:0], co16, ov16}) begin
            errors++;
            $display("FAIL sweep_d16[%0d]: got %h/%b/%b want %h/%b/%b", k, a_sum, a_cout, a_ovf, r16[15:0], co16, ov16);
          end
        end
        if (lb < 0 && b_done) begin
          lb = n;
          checks++;
          if ({b_sum, b_cout, b_ovf} !== {r16[15:0], co16, ov16}) begin
            errors++;
            $display("FAIL sweep_d1[%0d]: got %h/%b/%b want %h/%b/%b", k, b_sum, b_cout, b_ovf, r16[15:0], co16, ov16);
          end
        end
        if (lc < 0 && c_done) begin
          lc = n;
          checks++;
          if ({c_sum, c_cout, c_ovf} !== {r32, co32, ov32}) begin
            errors++;
            $display("FAIL sweep_w32[%0d]: got %h/%b/%b want %h/%b/%b", k, c_sum, c_cout, c_ovf, r32, co32, ov32);
          end
        end
        if (la >= 0 && lb >= 0 && lc >= 0) break;
        @(negedge clk);
        n++;
      end
      checks++; if (la != 1) begin errors++; $display("FAIL sweep_d16_latency[%0d]: got %0d want 1", k, la); end
      checks++; if (lb != 16) begin errors++; $display("FAIL sweep_d1_latency[%0d]: got %0d want 16", k, lb); end
      checks++; if (lc != 4) begin errors++; $display("FAIL sweep_w32_latency[%0d]: got %0d want 4", k, lc); end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0; c_in = 1'b0; x = '0; y = '0;
    sw_start = 1'b0; sw_sub = 1'b0; sw_cin = 1'b0;
    sw_x16 = '0; sw_y16 = '0; sw_x32 = '0; sw_y32 = '0;
    test_reset();
    test_add();
    test_carry_ovf();
    test_subtract();
    test_random_toggle();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_param_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/digit_serial_adder.md
Name: digit_serial_adder

Overview:
Parametrised multi-cycle adder/subtractor and the successor to the team's fixed 4-bit ripple adders. It processes a WIDTH-bit operand pair one DIGIT-bit slice per clock, LSB slice first, through a single DIGIT-bit adder slice with a registered carry. A start/busy/done handshake lets wide additions run in datapaths where a full-width ripple adder would not meet timing or area.

Parameters:
WIDTH, 16, operand and result width in bits; must be an integer multiple of DIGIT.
DIGIT, 4, bits processed per clock cycle; N_DIGITS = WIDTH/DIGIT, which must be at least 1.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous reset, active-high.
start  input  1  request to begin an operation; sampled on the rising edge.
sub  input  1  0 = add, 1 = subtract; captured with start.
x  input  WIDTH  operand A; captured with start.
y  input  WIDTH  operand B; captured with start.
c_in  input  1  carry-in when adding, borrow-in when subtracting; captured with start.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse; results are valid from this cycle onward.
sum  output  WIDTH  result (registered).
c_out  output  1  carry-out; for subtract, 1 = no borrow.
ovf  output  1  two's-complement signed overflow.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: state IDLE; busy, done, sum, c_out and ovf all 0; internal operand registers, digit counter and carry register all 0.
- FSM states:
  - IDLE: if start, go to RUN.
  - RUN: process one digit per edge; after the last digit, go to DONE.
  - DONE: lasts one cycle; if start, go to RUN (back-to-back operation); otherwise go to IDLE.
- Start capture (IDLE or DONE, start=1):
  - latch x into operand register A;
  - latch (sub ? ~y : y) into operand register B;
  - set carry register = sub ? ~c_in : c_in, so subtract computes x - y - c_in;
  - set digit counter to 0.
- Start while in RUN is ignored; captured operands are not disturbed.
- RUN, each edge:
  - add A[DIGIT-1:0] + B[DIGIT-1:0] + carry;
  - shift the DIGIT result bits into the top of the internal result shift register;
  - shift A and B right by DIGIT;
  - store the slice carry-out into the carry register;
  - increment the counter.
- Last digit (counter = N_DIGITS-1):
  - load sum from the final shift register contents;
  - load c_out from the final slice carry-out;
  - load ovf = carry into MSB XOR carry out of MSB, computed inside the final slice;
  - state -> DONE.
- Latency: start accepted on edge E0; busy=1 after E0; digits computed on edges E1..EN (N = N_DIGITS); after EN, done=1 and busy=0 for exactly one cycle.
  - With default parameters, done asserts 4 cycles after the start edge.
- N_DIGITS = 1: a single RUN cycle; done asserts 1 cycle after start.
- Output holding: sum, c_out and ovf hold the previous result throughout RUN and IDLE; they update only on the completing edge.
- Input changes: x, y, sub and c_in changing after capture have no effect on the operation in progress.
- Reset mid-operation: operation aborts, done is not pulsed, outputs return to 0.
- Reset has priority over start on the same edge.
- Arithmetic: all width rules are modulo 2^WIDTH; c_out and ovf follow standard two's-complement rules over the full WIDTH.

Test Plan:
- Add, WIDTH=16, DIGIT=4: x=0x1234, y=0x4321, sub=0, c_in=0 -> done exactly 4 cycles after the start edge; sum=0x5555, c_out=0, ovf=0; busy high for 4 cycles.
- Carry and overflow: 0xFFFF+0x0001 -> sum=0x0000, c_out=1, ovf=0. Then 0x7FFF+0x0001 -> sum=0x8000, c_out=0, ovf=1. Then 0x0000+0x0000 with c_in=1 -> sum=0x0001.
- Subtract: 0x0005-0x0007, c_in=0 -> sum=0xFFFE, c_out=0, ovf=0. Then 0x8000-0x0001 -> sum=0x7FFF, c_out=1, ovf=1. Then 0x0010-0x0001 with c_in=1 -> sum=0x000E.
- Handshake:
  - start re-pulsed mid-RUN with different operands -> ignored; first result still correct.
  - start held high in the DONE cycle -> second operation begins immediately; its done arrives 4 cycles later.
  - x and y are toggled during RUN -> result unaffected.
- Reset: assert rst 2 cycles into RUN -> busy=0, done never pulses, sum=0; a new start afterwards completes normally.
- Parameter sweep: DIGIT=16 (1 cycle), DIGIT=1 (16 cycles) and WIDTH=32/DIGIT=8 -> random operands, results checked against a reference model x ± y ± c_in, including c_out and ovf.
